bram_sweep_reader: RTL

//  Parametrised single-clock block RAM with a host write/read port (A) and an autonomous

---
 rtl/bram_sweep_reader_if.sv | 9 +
 rtl/bram_sweep_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bram_sweep_reader_if.sv
// bram_sweep_reader_if: valid/ready word stream from the sweep engine to its consumer
interface bram_sweep_reader_if #(parameter int DATA_W = 8);
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/bram_sweep_reader.sv
// bram_sweep_reader: host-port BRAM plus an autonomous address-window stream reader; define BRAM_SWEEP_LOOP_EN to honour the loop input
module bram_sweep_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                clka,
  input  logic                rsta_n,
  input  logic                ena,
  input  logic                wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  input  logic                loop,
  output logic                busy,
  output logic                done,
  bram_sweep_reader_if.master m
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int D = RD_LAT + 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q;
  logic [ADDR_W-1:0] rd_ptr_q, base_q;
  logic [ADDR_W:0]   rem_q, cnt_cfg_q;
  logic              loop_q, busy_q, done_q;
  logic [DATA_W-1:0] a1_q, b1_q;
  logic              v1_q, l1_q;
  logic [DATA_W:0]   fifo_q [4];
  logic [1:0]        wp_q, rp_q, fcnt_q;
  logic              push, push_l, pop, rd_en, idle, iss_last, iss_loop, loop_en;
  logic [DATA_W-1:0] push_d;
  logic [1:0]        inflight;
  logic [ADDR_W-1:0] iss_addr, iss_base;
  logic [ADDR_W:0]   iss_rem, iss_cnt;

  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W:0] x);
    return ADDR_W'(x % DEPTH_W);
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'(D-1) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef BRAM_SWEEP_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = loop & 1'b0;
`endif

  // The first read goes out on the start edge itself so the word lands RD_LAT+1 cycles later.
  always_comb begin
    idle     = state_q == IDLE;
    iss_base = idle ? wrap({1'b0, base_addr}) : base_q;
    iss_addr = idle ? iss_base : rd_ptr_q;
    iss_rem  = idle ? count : rem_q;
    iss_cnt  = idle ? count : cnt_cfg_q;
    iss_loop = idle ? loop_en : loop_q;
    iss_last = iss_rem == ONE;
    pop      = m.m_valid & m.m_ready;
    rd_en    = idle ? start & (count != '0)
                    : (state_q == RUN) & ({1'b0, fcnt_q} + {1'b0, inflight} < 3'(D) + {2'b0, pop});
  end

  // Non-blocking reads against the same-edge write give port B the old word on a collision.
  always_ff @(posedge clka) begin
    if (ena & wea) mem[wrap({1'b0, addra})] <= dina;
    if (rd_en) begin
      b1_q <= mem[iss_addr];
      l1_q <= iss_last;
    end
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      a1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= rd_en;
      if (ena) a1_q <= wea ? dina : mem[wrap({1'b0, addra})];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              ea1_q, v2_q, l2_q;
      logic [DATA_W-1:0] a2_q, b2_q;
      always_ff @(posedge clka) begin
        if (!rsta_n) begin
          ea1_q <= 1'b0;
          v2_q  <= 1'b0;
          a2_q  <= '0;
        end else begin
          ea1_q <= ena;
          v2_q  <= v1_q;
          if (ea1_q) a2_q <= a1_q;
        end
        if (v1_q) begin
          b2_q <= b1_q;
          l2_q <= l1_q;
        end
      end
      assign douta    = a2_q;
      assign push     = v2_q;
      assign push_d   = b2_q;
      assign push_l   = l2_q;
      assign inflight = 2'(v1_q) + 2'(v2_q);
    end else begin : g_lat1
      assign douta    = a1_q;
      assign push     = v1_q;
      assign push_d   = b1_q;
      assign push_l   = l1_q;
      assign inflight = {1'b0, v1_q};
    end
  endgenerate

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wp_q] <= {push_l, push_d};
        wp_q         <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
      fcnt_q <= fcnt_q + 2'(push) - 2'(pop);
    end
  end

  assign m.m_valid             = fcnt_q != '0;
  assign {m.m_last, m.m_data}  = fifo_q[rp_q];

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_ptr_q  <= '0;
      base_q    <= '0;
      rem_q     <= '0;
      cnt_cfg_q <= '0;
      loop_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (idle & start) begin
        base_q    <= iss_base;
        cnt_cfg_q <= count;
        loop_q    <= loop_en;
        busy_q    <= count != '0;
        done_q    <= count == '0;
        if (count != '0) state_q <= RUN;
      end
      if (rd_en) begin
        rd_ptr_q <= wrap({1'b0, iss_addr} + ONE);
        rem_q    <= iss_rem - ONE;
        if (iss_last) begin
          if (iss_loop) begin
            rd_ptr_q <= iss_base;
            rem_q    <= iss_cnt;
          end else state_q <= DRAIN;
        end
      end
      if ((state_q == DRAIN) & pop & m.m_last) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
endmodule
